// File: rtl/ram_ctrl.sv
// Synchronous single-port RAM behind a registered cs/req/rdy handshake,
// with programmable wait states, byte-lane write enables and range checking.
module ram_ctrl #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int MEM_DEPTH   = 16384,
  parameter int WAIT_STATES = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cs,
  input  logic                    req,
  input  logic                    read,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] be,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rdy,
  output logic                    rvalid,
  output logic                    err
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [3:0] WS_L = 4'(WAIT_STATES);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                 state_q;
  logic [3:0]             cnt_q;
  logic                   read_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic [BE_W-1:0]        be_q;
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic                   rdy_q;
  logic                   rvalid_q;
  logic                   err_q;

  logic [DATA_WIDTH-1:0]  mem_q [MEM_DEPTH];

  logic                   complete_s;
  logic                   in_range_s;
  logic [IDX_W-1:0]       idx_s;

  // Full-width range compare so high address bits can never alias into the array.
  always_comb begin
    in_range_s = ({1'b0, addr_q} < DEPTH_L);
    complete_s = (state_q == BUSY) && (cnt_q == 4'd0);
    idx_s      = addr_q[IDX_W-1:0];
  end

  // Memory array: byte-lane writes at completion only; never reset.
  always_ff @(posedge clk) begin
    if (rst_n && complete_s && !read_q && in_range_s) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be_q[i]) begin
          mem_q[idx_s][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  // Handshake FSM, wait counter and registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      read_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      rdata_q  <= '0;
      rdy_q    <= 1'b1;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cs && req) begin
            read_q  <= read;
            addr_q  <= address;
            wdata_q <= wdata;
            be_q    <= be;
            cnt_q   <= WS_L;
            state_q <= BUSY;
            rdy_q   <= 1'b0;
          end else begin
            rdy_q   <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q <= IDLE;
            rdy_q   <= 1'b1;
            err_q   <= !in_range_s;
            if (read_q) begin
              rvalid_q <= 1'b1;
              rdata_q  <= in_range_s ? mem_q[idx_s] : '0;
            end else begin
              rvalid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          rdy_q   <= 1'b1;
        end
      endcase
    end
  end

  assign rdata  = rdata_q;
  assign rdy    = rdy_q;
  assign rvalid = rvalid_q;
  assign err    = err_q;

endmodule

// File: tb/tb_ram_ctrl.sv
// Scoreboard bench for ram_ctrl: three instances (1, 0 and 3 wait states)
// checked against an associative-array memory model.
module tb_ram_ctrl;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int DEPTH = 16384;
  localparam int BW = 2;
  localparam int N = 3;

  typedef struct {
    int              inst;
    logic            rv;
    logic            er;
    logic [DW-1:0]   data;
    int              cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]          rst_n, cs, req, rdy, rvalid, err;
  logic                  read;
  logic [AW-1:0]         address;
  logic [DW-1:0]         wdata;
  logic [BW-1:0]         be;
  logic [N-1:0][DW-1:0]  rdata;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  exp_t exp_q[$];
  logic [DW-1:0] model [int];

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < N; g++) begin : g_dut
    ram_ctrl #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH),
      .WAIT_STATES((g == 0) ? 1 : ((g == 1) ? 0 : 3))
    ) u_dut (
      .clk(clk), .rst_n(rst_n[g]), .cs(cs[g]), .req(req[g]), .read(read),
      .address(address), .wdata(wdata), .be(be), .rdata(rdata[g]),
      .rdy(rdy[g]), .rvalid(rvalid[g]), .err(err[g])
    );
  end

  function automatic int ws_of(input int g);
    case (g)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Drive one access, record its expected response, then count rdy-low cycles.
  task automatic issue(input int g, input logic rd, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [BW-1:0] b,
                       input bit hold, output int acc_cyc);
    int n;
    int key;
    logic [DW-1:0] m;
    exp_t e;
    n = 0;
    while (!rdy[g] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rdy_before_issue", 32'(rdy[g]), 32'd1);
    cs[g] = 1'b1; req[g] = 1'b1;
    read = rd; address = a; wdata = d; be = b;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    key = g * 65536 + int'(a);
    e.inst = g; e.cyc = cyc + ws_of(g) + 1; e.data = '0;
    if (int'(a) >= DEPTH) begin
      e.rv = rd; e.er = 1'b1;
      exp_q.push_back(e);
    end else if (rd) begin
      e.rv = 1'b1; e.er = 1'b0; e.data = model[key];
      exp_q.push_back(e);
    end else begin
      m = model.exists(key) ? model[key] : '0;
      for (int i = 0; i < BW; i++) if (b[i]) m[8*i +: 8] = d[8*i +: 8];
      model[key] = m;
    end
    read = 1'($urandom); address = AW'($urandom); wdata = DW'($urandom); be = BW'($urandom);
    if (!hold) begin
      cs[g] = 1'b0; req[g] = 1'b0;
    end
    n = 0;
    @(negedge clk);
    while (!rdy[g] && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("rdy_low_cycles", 32'(n), 32'(ws_of(g) + 1));
  endtask

  // Monitor: pops the scoreboard on every response and checks rdata holding.
  initial begin : monitor
    logic [N-1:0][DW-1:0] last;
    exp_t e;
    last = '0;
    forever begin
      @(negedge clk);
      for (int g = 0; g < N; g++) begin
        if (!rst_n[g]) begin
          last[g] = '0;
        end else begin
          if (rvalid[g] || err[g]) begin
            if (exp_q.size() == 0) begin
              tests++; fails++;
              $display("FAIL unexpected_response: inst %0d rvalid %0b err %0b, expected no response",
                       g, rvalid[g], err[g]);
            end else begin
              e = exp_q.pop_front();
              check("resp_inst", 32'(g), 32'(e.inst));
              check("resp_rvalid", 32'(rvalid[g]), 32'(e.rv));
              check("resp_err", 32'(err[g]), 32'(e.er));
              check("resp_cycle", 32'(cyc), 32'(e.cyc));
              if (e.rv) check("resp_rdata", 32'(rdata[g]), 32'(e.data));
            end
          end
          if (!rvalid[g]) check("rdata_hold", 32'(rdata[g]), 32'(last[g]));
          last[g] = rdata[g];
        end
      end
    end
  end

  task automatic random_run(input int g, input int count);
    int addrs[$];
    int a, c, r;
    for (int k = 0; k < count; k++) begin
      r = int'($urandom_range(0, 5));
      if (addrs.size() == 0 || r == 0) begin
        a = int'($urandom_range(0, DEPTH - 1));
        addrs.push_back(a);
        issue(g, 1'b0, AW'(a), DW'($urandom), 2'b11, 1'b0, c);
      end else if (r == 1) begin
        issue(g, 1'($urandom), AW'($urandom_range(DEPTH, 65535)), DW'($urandom), BW'($urandom), 1'b0, c);
      end else if (r == 2) begin
        a = addrs[$urandom_range(0, addrs.size() - 1)];
        issue(g, 1'b0, AW'(a), DW'($urandom), BW'($urandom), 1'b0, c);
      end else begin
        a = addrs[$urandom_range(0, addrs.size() - 1)];
        issue(g, 1'b1, AW'(a), '0, '0, 1'b0, c);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin : stim
    int c0, c1, c2, n;
    rst_n = '0; cs = '0; req = '0;
    read = 1'b0; address = '0; wdata = '0; be = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < N; g++) begin
      check("reset_rdy", 32'(rdy[g]), 32'd1);
      check("reset_rvalid", 32'(rvalid[g]), 32'd0);
      check("reset_err", 32'(err[g]), 32'd0);
      check("reset_rdata", 32'(rdata[g]), 32'h0);
    end
    rst_n = '1;
    @(negedge clk);

    // Directed traffic on the one-wait-state instance.
    issue(0, 1'b0, 16'h0000, 16'h1357, 2'b11, 1'b0, c0);
    issue(0, 1'b0, 16'h0010, 16'hBEEF, 2'b11, 1'b0, c0);
    issue(0, 1'b1, 16'h0010, 16'h0000, 2'b00, 1'b0, c0);
    issue(0, 1'b0, 16'h0020, 16'hFFFF, 2'b11, 1'b0, c0);
    issue(0, 1'b0, 16'h0020, 16'h1234, 2'b01, 1'b0, c0);
    issue(0, 1'b1, 16'h0020, 16'h0000, 2'b00, 1'b0, c0);
    issue(0, 1'b0, 16'h0020, 16'h5A5A, 2'b00, 1'b0, c0);
    issue(0, 1'b1, 16'h0020, 16'h0000, 2'b00, 1'b0, c0);
    check("be_model_value", 32'(model[16'h0020]), 32'h0000FF34);
    issue(0, 1'b0, 16'h4000, 16'hAAAA, 2'b11, 1'b0, c0);
    issue(0, 1'b1, 16'h4000, 16'h0000, 2'b00, 1'b0, c0);
    issue(0, 1'b1, 16'h0000, 16'h0000, 2'b00, 1'b0, c0);

    // Back-to-back reads with req held high on the zero-wait instance.
    issue(1, 1'b0, 16'h0010, 16'h1111, 2'b11, 1'b0, c0);
    issue(1, 1'b0, 16'h0020, 16'h2222, 2'b11, 1'b0, c0);
    issue(1, 1'b0, 16'h0030, 16'h3333, 2'b11, 1'b0, c0);
    issue(1, 1'b1, 16'h0010, 16'h0000, 2'b00, 1'b1, c0);
    issue(1, 1'b1, 16'h0020, 16'h0000, 2'b00, 1'b1, c1);
    issue(1, 1'b1, 16'h0030, 16'h0000, 2'b00, 1'b0, c2);
    check("b2b_spacing_1", 32'(c1 - c0), 32'd2);
    check("b2b_spacing_2", 32'(c2 - c1), 32'd2);

    // Reset two edges into a three-wait-state write discards it.
    issue(2, 1'b0, 16'h0010, 16'hBEEF, 2'b11, 1'b0, c0);
    cs[2] = 1'b1; req[2] = 1'b1; read = 1'b0; address = 16'h0010; wdata = 16'h5555; be = 2'b11;
    @(posedge clk);
    #1;
    cs[2] = 1'b0; req[2] = 1'b0; address = 16'h0000; wdata = 16'h0000;
    check("midwrite_busy", 32'(rdy[2]), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n[2] = 1'b0;
    #1;
    check("midwrite_reset_rdy", 32'(rdy[2]), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n[2] = 1'b1;
    issue(2, 1'b1, 16'h0010, 16'h0000, 2'b00, 1'b0, c0);

    random_run(0, 120);
    random_run(1, 120);
    random_run(2, 40);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ram_ctrl.md
Name: ram_ctrl

Overview:
- Parametrised synchronous single-port RAM with a registered cs/req/rdy request handshake, programmable wait states and byte-lane write enables.
- Successor to the fixed 16x16K bidirectional-bus RAM.
- Separate read and write data buses; no tri-state.
- Sits on the processor memory bus and serves instruction and data accesses from the core's bus interface unit.

Parameters:
- DATA_WIDTH, 16, data word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 16, address bus width in bits.
- MEM_DEPTH, 16384, number of words implemented; must be <= 2**ADDR_WIDTH.
- WAIT_STATES, 1, extra busy cycles inserted before each access completes; range 0..15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cs  input  1  chip select.
- req  input  1  access request; qualified by cs.
- read  input  1  1 = read, 0 = write; sampled at accept.
- address  input  ADDR_WIDTH  word address; sampled at accept.
- wdata  input  DATA_WIDTH  write data; sampled at accept.
- be  input  DATA_WIDTH/8  byte enables for writes; bit i enables byte i (bits 8i+7..8i). Ignored on reads.
- rdata  output  DATA_WIDTH  read data. Registered; holds its value until the next completed read.
- rdy  output  1  1 = idle and able to accept a request.
- rvalid  output  1  one-cycle pulse: rdata is updated this cycle.
- err  output  1  one-cycle pulse: the completed access addressed a location >= MEM_DEPTH.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, rdy=1, rvalid=0, err=0, rdata=0, wait counter=0. Memory array contents are not cleared.
- States are IDLE and BUSY.
- IDLE:
  - rdy=1.
  - On a rising edge with cs&req=1: latch read, address, wdata and be. Load the counter with WAIT_STATES, go to BUSY, set rdy=0.
  - cs&req=0 leaves the block in IDLE with no memory effect.
- BUSY:
  - rdy=0. cs, req, address, wdata and be are ignored; only the latched copies are used.
  - On each edge where counter!=0, decrement the counter.
  - On the edge where counter==0, complete the access and return to IDLE with rdy=1.
- Completion, write, in range: for each i with be[i]=1, write byte i of the latched wdata into the addressed word. Bytes with be[i]=0 are unchanged. be=0 is a legal no-op.
- Completion, read, in range: rdata = memory word; rvalid=1 for one cycle.
- Completion, out of range (latched address >= MEM_DEPTH):
  - err=1 for one cycle and the memory is not modified.
  - A read returns rdata=0 with rvalid=1.
- Latency:
  - Accept at edge E0; completion at edge E0+WAIT_STATES+1.
  - rdy is low for WAIT_STATES+1 cycles.
  - With req held high, a new request is accepted at the edge after completion.
  - Peak throughput: one access per WAIT_STATES+2 cycles.
- Read-after-write to the same address returns the newly written data; there is no bypass hazard.
- rvalid and err are each cleared on the edge after the one that set them.
- Reset mid-operation: BUSY aborts to IDLE immediately. A pending write that has not reached completion is discarded, and memory is unchanged.
- Address decoding uses the full ADDR_WIDTH compare against MEM_DEPTH. Upper address bits are never silently truncated.
- Arithmetic: the counter is 4 bits and does not wrap; it is reloaded only at accept.

Test Plan:
- Reset, then idle: rst_n low for 2 cycles, then high -> rdy=1, rvalid=0, err=0, rdata=0x0000.
- Write then read, WAIT_STATES=1:
  - Write 0xBEEF to address 0x0010 with be=2'b11 -> rdy low for exactly 2 cycles.
  - Read of 0x0010 -> rvalid pulses once with rdata=0xBEEF, at accept edge + 2.
- Byte enables:
  - Write 0xFFFF to 0x0020, then write 0x1234 with be=2'b01.
  - Read 0x0020 -> 0xFF34. A further write with be=2'b00 leaves the value at 0xFF34.
- Out of range:
  - Write 0xAAAA to address 0x4000 -> err pulses, rvalid=0.
  - Read 0x4000 -> rdata=0x0000, err=1, rvalid=1.
  - Address 0x0000 is unaffected.
- Back-to-back with WAIT_STATES=0:
  - req held high for reads of 0x0010, 0x0020, 0x0030 -> rdy low for 1 cycle each; one access every 2 cycles.
  - Inputs changed while BUSY are ignored.
- Reset mid-write: accept a write of 0x5555 to 0x0010 with WAIT_STATES=3, then assert rst_n low at edge +2 -> rdy=1 immediately, and a later read of 0x0010 returns 0xBEEF.
